// File: rtl/fifo_stream_reader.sv
// Purpose : read-side consumer for a registered-read FIFO; re-times words into a valid/ready stream with frame marks.
// Latency : fifo_rd_en in cycle N -> word captured at end of N+1 -> m_valid in N+2 (empty buffer); 1 word/cycle sustained.
// Backpressure: 2-entry head+skid buffer; a read is issued only when buffered + in-flight words after this cycle's pop stay below 2.
//
// Ports:
//   clk, rst_n            clock (posedge) and synchronous active-low reset
//   fifo_empty/fifo_data  FIFO status and registered read data (valid the cycle after a read edge)
//   fifo_rd_en            FIFO read strobe
//   m_valid/m_ready       output handshake; m_data, m_last qualified by m_valid
//   word_count            total words accepted downstream since reset (wraps)
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 6,
    parameter int FRAME_LEN  = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int FIDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(FRAME_LEN - 1);

    logic [DATA_WIDTH-1:0] head, head_nxt;
    logic [DATA_WIDTH-1:0] skid, skid_nxt;
    logic [1:0]            occ, occ_nxt;
    logic                  inflight;
    logic                  valid_q;
    logic [FIDX_W-1:0]     fidx;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  pop;
    logic [2:0]            level;

    assign pop = valid_q & m_ready;

    // Words that will still be held (buffered or in flight) after this cycle's pop.
    // m_ready feeds fifo_rd_en combinationally so a full buffer that is draining
    // this cycle can still request the next word and keep 1 word/cycle.
    assign level      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_rd_en = rst_n & ~fifo_empty & (level < 3'd2);

    assign m_valid    = valid_q;
    assign m_data     = head;
    assign m_last     = valid_q & (fidx == FIDX_LAST);
    assign word_count = cnt;

    always_comb begin
        occ_nxt  = occ;
        head_nxt = head;
        skid_nxt = skid;
        if (inflight) begin
            case (occ)
                2'd0: begin
                    head_nxt = fifo_data;
                    occ_nxt  = 2'd1;
                end
                2'd1: begin
                    if (pop) begin
                        head_nxt = fifo_data;
                    end else begin
                        skid_nxt = fifo_data;
                        occ_nxt  = 2'd2;
                    end
                end
                default: begin
                    // occ=2 with no pop cannot coexist with a capture (see assertion).
                    if (pop) begin
                        head_nxt = skid;
                        skid_nxt = fifo_data;
                    end
                end
            endcase
        end else if (pop) begin
            if (occ == 2'd2) begin
                head_nxt = skid;
                occ_nxt  = 2'd1;
            end else begin
                occ_nxt  = 2'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head     <= '0;
            skid     <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            valid_q  <= 1'b0;
            fidx     <= '0;
            cnt      <= '0;
        end else begin
            head     <= head_nxt;
            skid     <= skid_nxt;
            occ      <= occ_nxt;
            inflight <= fifo_rd_en;
            valid_q  <= (occ_nxt != 2'd0);
            if (pop) begin
                fidx <= (fidx == FIDX_LAST) ? '0 : fidx + FIDX_W'(1);
                cnt  <= cnt + CNT_WIDTH'(1);
            end
        end
    end

    // A capture into a full buffer would lose a word; the read credit rule forbids it.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (inflight && occ == 2'd2) |-> pop);

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int DW = 6;
    localparam int FL = 7;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] word_count;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .word_count (word_count)
    );

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];     // {last, data}
    int            push_idx  = 0;
    int            checks    = 0;
    int            failures  = 0;
    int            held      = 0;
    int            exp_cnt   = 0;
    int            rst_edges = 0;
    int            tot_pops  = 0;
    logic          rd_s = 1'b0;
    logic          pop_s = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back({(push_idx == FL - 1), d});
        push_idx   = (push_idx == FL - 1) ? 0 : push_idx + 1;
        fifo_empty = 1'b0;
    endtask

    // FIFO model: registered read port, data one cycle after the read edge.
    always @(posedge clk) begin
        if (rd_s && fifo_q.size() > 0)
            fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
        if (!rst_n) begin
            held    = 0;
            exp_cnt = 0;
            rst_edges++;
        end else begin
            held = held + int'(rd_s) - int'(pop_s);
            if (pop_s) begin
                exp_cnt++;
                tot_pops++;
            end
            rst_edges = 0;
        end
    end

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        rd_s  = fifo_rd_en;
        pop_s = m_valid && m_ready && rst_n;
        if (!rst_n) begin
            chk("rd_en_in_reset", fifo_rd_en, 0);
            if (rst_edges > 0) begin
                chk("reset_m_valid", m_valid, 0);
                chk("reset_m_data", m_data, 0);
                chk("reset_m_last", m_last, 0);
                chk("reset_word_count", word_count, 0);
            end
            stall_prev = 1'b0;
        end else begin
            if (fifo_rd_en)
                chk("rd_when_empty", fifo_empty, 0);
            chk("credit_le_2", (held + int'(fifo_rd_en) - int'(pop_s)) <= 2, 1);
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
                chk("stall_last", m_last, prev_last);
            end
            if (pop_s) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", m_data, -1);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    chk("data", m_data, e[DW-1:0]);
                    chk("last", m_last, e[DW]);
                    chk("word_count", word_count, exp_cnt % (1 << CW));
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        push_idx   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 4000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target);
        int n;
        n = 0;
        while (tot_pops < target && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_pops_timeout: got %0d pops expected %0d", tot_pops, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int pushed;
        int n;

        // 1: reset held 3 cycles with a non-empty FIFO.
        push_word(6'h15);
        repeat (3) @(posedge clk);
        #1;
        fifo_q.delete();
        exp_q.delete();
        push_idx   = 0;
        fifo_empty = 1'b1;
        rst_n      = 1'b1;
        m_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 2: single word, latency rd_en(N) -> m_valid(N+2).
        push_word(6'h2A);
        @(negedge clk);
        chk("t2_rd_N", fifo_rd_en, 1);
        chk("t2_valid_N", m_valid, 0);
        @(negedge clk);
        chk("t2_rd_N1", fifo_rd_en, 0);
        chk("t2_valid_N1", m_valid, 0);
        @(negedge clk);
        chk("t2_valid_N2", m_valid, 1);
        chk("t2_data_N2", m_data, 'h2A);
        @(negedge clk);
        chk("t2_valid_N3", m_valid, 0);
        chk("t2_count", word_count, 1);
        drain();

        // 3: 14 words back to back, lasts on words 6 and 13.
        do_reset();
        for (int i = 0; i < 14; i++) push_word(DW'(i));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 20);
        chk("t3_first_valid", m_valid, 1);
        repeat (13) begin
            @(negedge clk);
            chk("t3_back_to_back", m_valid, 1);
        end
        drain();
        chk("t3_count", word_count, 14);

        // 4: 20 words with a 5-cycle downstream stall mid-stream.
        for (int i = 0; i < 20; i++) push_word(DW'(i));
        wait_pops(tot_pops + 5);
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_stall_no_read", fifo_rd_en, 0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        drain();
        chk("t4_count", word_count, 34);

        // 5: random ready and random FIFO fill gaps, 1000 words.
        pushed = 0;
        while (pushed < 1000) begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                push_word(DW'($urandom));
                pushed++;
            end
        end
        m_ready = 1'b1;
        drain();
        chk("t5_count", word_count, 1034);

        // 6: reset after 3 words of a frame; frame and count restart.
        do_reset();
        for (int i = 0; i < 3; i++) push_word(DW'(40 + i));
        drain();
        chk("t6_pre_count", word_count, 3);
        do_reset();
        chk("t6_count_cleared", word_count, 0);
        for (int i = 0; i < 7; i++) push_word(DW'(50 + i));
        drain();
        chk("t6_count", word_count, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
